seq_mult_ctl: RTL

- Parametrised iterative shift-add multiplier with a start/busy/done handshake, signed/unsigned mode per operation, and early termination.
- Operands are captured on `start` rather than on reset.
- The result is held stable until the next accepted operation.
- Sits as a multi-cycle arithmetic unit beside the datapath. Replaces the fixed 8-bit reset-loaded multiplier.

---
 rtl/seq_mult_ctl_if.sv | 12 +
 rtl/seq_mult_ctl.sv | 48 ++++
 2 files changed

// File: rtl/seq_mult_ctl_if.sv
// seq_mult_ctl_if: start/busy/done handshake bundle (start, signed_mode, a, b in; busy, done, product out) for seq_mult_ctl
interface seq_mult_ctl_if #(parameter int WIDTH = 8);
  logic start;
  logic signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, signed_mode, a, b, input busy, done, product);
  modport slave (input start, signed_mode, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_ctl.sv
// seq_mult_ctl: iterative shift-add multiplier; clk, reset (sync, active-high), bus = slave handshake (start/signed_mode/a/b in, busy/done/product out)
module seq_mult_ctl #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  seq_mult_ctl_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_n;
  logic [W2-1:0] ma, acc, prod;
  logic [WIDTH-1:0] mb, mag_a, mag_b;
  logic neg, busy, accept;
  assign busy = state == RUN || state == FIX;
  assign accept = bus.start && !busy;
  assign bus.busy = busy;
  assign bus.done = state == DONE;
  assign bus.product = prod;
  assign mag_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  always_comb begin
    state_n = state;
    state_n = busy ? (state == FIX ? DONE : ((mb >> 1) == '0 ? FIX : RUN))
                   : (bus.start ? RUN : state);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      ma <= '0;
      mb <= '0;
      acc <= '0;
      neg <= 1'b0;
      prod <= '0;
    end else if (accept) begin
      ma <= {{WIDTH{1'b0}}, mag_a};
      mb <= mag_b;
      acc <= '0;
      neg <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else if (state == RUN) begin
      acc <= mb[0] ? acc + ma : acc;
      ma <= ma << 1;
      mb <= mb >> 1;
    end else if (state == FIX) begin
      prod <= neg ? -acc : acc;
    end
  end
endmodule
